// File: rtl/systolic_pkg.sv
// systolic_pkg: shared state encoding and sizing helpers for the systolic sequencer
package systolic_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, FEED, DONE} seq_state_t;
  function automatic int feed_cycles(input int n);
    return 3 * n - 2;
  endfunction
  function automatic int step_width(input int n);
    int c = $clog2(feed_cycles(n));
    return c < 1 ? 1 : c;
  endfunction
endpackage

// File: rtl/systolic_sequencer_if.sv
// systolic_sequencer_if: command side and array side of the systolic sequencer
interface systolic_sequencer_if #(
  parameter int MATRIX_SIZE = 3,
  parameter int DATA_WIDTH  = 8
);
  logic start;
  logic abort;
  logic [MATRIX_SIZE-1:0][MATRIX_SIZE-1:0][DATA_WIDTH-1:0] a_mat;
  logic [MATRIX_SIZE-1:0][MATRIX_SIZE-1:0][DATA_WIDTH-1:0] b_mat;
  logic busy;
  logic done;
  logic arr_clr;
  logic arr_en;
  logic [MATRIX_SIZE-1:0][DATA_WIDTH-1:0] arr_left;
  logic [MATRIX_SIZE-1:0][DATA_WIDTH-1:0] arr_top;
  modport master (output start, abort, a_mat, b_mat,
                  input  busy, done, arr_clr, arr_en, arr_left, arr_top);
  modport slave  (input  start, abort, a_mat, b_mat,
                  output busy, done, arr_clr, arr_en, arr_left, arr_top);
endinterface

// File: rtl/skew_feeder.sv
// skew_feeder: diagonal skew of captured operands onto the array's left/top edges
module skew_feeder
  import systolic_pkg::*;
#(
  parameter int N  = 3,
  parameter int DW = 8,
  parameter int SW = 3
) (
  input  logic [N-1:0][N-1:0][DW-1:0] a_q,
  input  logic [N-1:0][N-1:0][DW-1:0] b_q,
  input  logic [SW-1:0]               t,
  input  logic                        feed,
  output logic [N-1:0][DW-1:0]        arr_left,
  output logic [N-1:0][DW-1:0]        arr_top
);
  localparam int IW = N > 1 ? $clog2(N) : 1;
  // lane i sees operand index k = t - i; the range check guards every select
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [SW-1:0] k;
    logic          hit;
    assign k   = t - SW'(i);
    assign hit = feed && t >= SW'(i) && k < SW'(N);
    assign arr_left[i] = hit ? a_q[i][k[IW-1:0]] : '0;
    assign arr_top[i]  = hit ? b_q[k[IW-1:0]][i] : '0;
  end
endmodule

// File: rtl/systolic_sequencer.sv
// systolic_sequencer: captures A/B, clears the MAC array, streams skewed operands, pulses done
module systolic_sequencer
  import systolic_pkg::*;
#(
  parameter int MATRIX_SIZE = 3,
  parameter int DATA_WIDTH  = 8
) (
  input logic clk,
  input logic rst,
  systolic_sequencer_if.slave bus
);
  localparam int SW   = step_width(MATRIX_SIZE);
  localparam int LAST = feed_cycles(MATRIX_SIZE) - 1;
  seq_state_t state, nxt;
  logic [SW-1:0] t;
  logic [MATRIX_SIZE-1:0][MATRIX_SIZE-1:0][DATA_WIDTH-1:0] a_q, b_q;
  logic accept;
  assign accept = state == IDLE && bus.start && !bus.abort;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      t     <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      state <= nxt;
      t     <= state == FEED ? t + SW'(1) : '0;
      if (accept) begin
        a_q <= bus.a_mat;
        b_q <= bus.b_mat;
      end
    end
  always_comb begin
    nxt = bus.abort       ? IDLE :
          state == IDLE   ? (bus.start ? CLEAR : IDLE) :
          state == CLEAR  ? FEED :
          state == FEED   ? (t == SW'(LAST) ? DONE : FEED) : IDLE;
  end
  assign bus.busy    = state != IDLE;
  assign bus.done    = state == DONE;
  assign bus.arr_clr = state == CLEAR;
  assign bus.arr_en  = state == FEED;
  skew_feeder #(.N(MATRIX_SIZE), .DW(DATA_WIDTH), .SW(SW)) u_feed (
    .a_q      (a_q),
    .b_q      (b_q),
    .t        (t),
    .feed     (state == FEED),
    .arr_left (bus.arr_left),
    .arr_top  (bus.arr_top)
  );
endmodule
